// File: rtl/count_sequence_checker.sv
// Monitors a free-running counter: every enabled sample must equal the previous one + 1 (mod 2^W).
// Locks after LOCK_COUNT good steps, then flags/counts breaks and counts wraps.
module count_sequence_checker #(
    parameter int PROG_VALUE = 3,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_WIDTH  = 8,
    parameter int WRAP_WIDTH = 16,
    localparam int W = $clog2(PROG_VALUE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [W-1:0]          count_in,
    input  logic                  clear,
    output logic                  locked,
    output logic                  mismatch,
    output logic                  sticky_err,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [WRAP_WIDTH-1:0] wrap_count,
    output logic [W-1:0]          expected
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_LOCKED
    } state_t;

    state_t                r_state;
    logic [RUN_W-1:0]      r_run;
    logic                  r_locked;
    logic                  r_mismatch;
    logic                  r_sticky_err;
    logic [ERR_WIDTH-1:0]  r_err_count;
    logic [WRAP_WIDTH-1:0] r_wrap_count;
    logic [W-1:0]          r_expected;

    logic                  w_match;
    logic [W-1:0]          w_next_exp;
    logic [RUN_W-1:0]      w_run_inc;
    logic [ERR_WIDTH-1:0]  w_err_base;
    logic [ERR_WIDTH-1:0]  w_err_next;
    logic [WRAP_WIDTH-1:0] w_wrap_base;

    assign w_match    = (count_in == r_expected);
    assign w_next_exp = count_in + W'(1);
    assign w_run_inc  = r_run + RUN_W'(1);

    // A same-cycle clear is applied first so a coincident event still counts once.
    assign w_err_base  = clear ? '0 : r_err_count;
    assign w_err_next  = (w_err_base == '1) ? w_err_base : w_err_base + ERR_WIDTH'(1);
    assign w_wrap_base = clear ? '0 : r_wrap_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_run        <= '0;
            r_locked     <= 1'b0;
            r_mismatch   <= 1'b0;
            r_sticky_err <= 1'b0;
            r_err_count  <= '0;
            r_wrap_count <= '0;
            r_expected   <= '0;
        end else begin
            r_mismatch <= 1'b0;
            if (clear) begin
                r_err_count  <= '0;
                r_sticky_err <= 1'b0;
                r_wrap_count <= '0;
            end
            if (enable) begin
                r_expected <= w_next_exp;
                case (r_state)
                    S_IDLE: begin
                        r_run   <= '0;
                        r_state <= S_SYNC;
                    end
                    S_SYNC: begin
                        if (w_match) begin
                            r_run <= w_run_inc;
                            if (w_run_inc == RUN_W'(LOCK_COUNT)) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_run <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (w_match) begin
                            if (count_in == '0) begin
                                r_wrap_count <= w_wrap_base + WRAP_WIDTH'(1);
                            end
                        end else begin
                            r_mismatch   <= 1'b1;
                            r_sticky_err <= 1'b1;
                            r_err_count  <= w_err_next;
                            r_locked     <= 1'b0;
                            r_run        <= '0;
                            r_state      <= S_SYNC;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign locked     = r_locked;
    assign mismatch   = r_mismatch;
    assign sticky_err = r_sticky_err;
    assign err_count  = r_err_count;
    assign wrap_count = r_wrap_count;
    assign expected   = r_expected;

endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
Downstream monitor for the n_bit_counter output; samples the counter value and confirms each sample equals the previous sample + 1, modulo 2^W. It acquires lock after a run of consecutive good steps, flags and counts sequence breaks, and counts wrap-arounds while locked. Used in the lab datapath to qualify the counter before its count is consumed.

Parameters:
PROG_VALUE, 3, counter program value; W = $clog2(PROG_VALUE); legal range PROG_VALUE >= 2
LOCK_COUNT, 4, consecutive matching samples needed to enter LOCKED; legal range >= 1
ERR_WIDTH, 8, width of err_count
WRAP_WIDTH, 16, width of wrap_count

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  sample count_in on this rising edge when 1
count_in  input  W  value from the upstream counter
clear  input  1  synchronous clear of err_count, sticky_err and wrap_count
locked  output  1  1 while in LOCKED
mismatch  output  1  one-cycle pulse per sequence break detected in LOCKED
sticky_err  output  1  set on any mismatch; held until clear or reset
err_count  output  ERR_WIDTH  mismatch count; saturates at all-ones
wrap_count  output  WRAP_WIDTH  locked wraps (max to 0); rolls over freely
expected  output  W  next value the checker expects

Behaviour:
- Reset: asynchronous and immediate. State is IDLE. locked, mismatch, sticky_err, err_count, wrap_count, expected and the internal run counter are all 0.
- All outputs are registered. A sample taken at edge k affects outputs from edge k onward.
- enable = 0: no comparison, state frozen, mismatch = 0. clear still acts.
- expected update: every enabled sample sets expected = (count_in + 1) truncated to W bits. Example with W = 2: count_in = 3 gives expected = 0.
- State IDLE: the first enabled sample anchors expected, sets run = 0 and moves to SYNC. No compare.
- State SYNC:
  - Enabled sample with count_in == expected: run++. When run reaches LOCK_COUNT, go to LOCKED and set locked = 1.
  - Enabled sample with count_in != expected: run = 0, re-anchor expected, stay in SYNC.
  - No mismatch pulse and no counter updates occur in SYNC.
- State LOCKED, enabled sample:
  - Match: stay in LOCKED. If count_in == 0, wrap_count++.
  - No match: assert mismatch for exactly one cycle. Set sticky_err = 1. err_count++, saturating at 2^ERR_WIDTH - 1. Clear locked, re-anchor expected, run = 0, go to SYNC.
- LOCK_COUNT = 1: a single match after the anchor locks.
- clear (synchronous):
  - Zeroes err_count, sticky_err and wrap_count. Does not change state, locked or expected.
  - clear in the same cycle as a mismatch: the mismatch wins, giving err_count = 1 and sticky_err = 1.
  - clear in the same cycle as a wrap: wrap_count = 1.
- A reset asserted mid-operation aborts everything; nothing is retained.

Test Plan:
1. Lock and wrap: PROG_VALUE = 3, LOCK_COUNT = 4, enable = 1, count 0,1,2,3,0,1,2,3,0 -> anchor on the first 0. locked = 1 after the sample of the second 0 (its 3->0 step is not counted, since the checker is still in SYNC). wrap_count = 1 after the third 0. mismatch never asserts.
2. Break: once locked, feed 1,2,0 -> on the 0 sample mismatch is high for one cycle, err_count = 1, sticky_err = 1, locked = 0. Continue 1,2,3,0 -> relocked, sticky_err stays 1.
3. Enable gaps: locked, enable toggles 1,0,0,1 while count_in is held then advances by 1 -> no mismatch, locked stays 1, counters unchanged.
4. Saturation: ERR_WIDTH = 2, five break-and-relock cycles -> err_count reads 1,2,3,3,3.
5. Clear: clear coincident with a mismatch -> err_count = 1, sticky_err = 1. A later clear alone -> err_count = 0, sticky_err = 0, wrap_count = 0, locked unchanged.
6. Async reset: assert reset between clock edges while LOCKED with err_count = 2 -> all outputs are 0 before the next edge. After release, the first enabled sample re-anchors in IDLE.
